// File: rtl/cog_pkg.sv
// Shared definitions for the cog capture block: capture mode encodings,
// FSM state type, configuration word bit-field positions and a decoder
// that unpacks the configuration word into a structured form.
package cog_pkg;

  typedef enum logic [1:0] {
    CAP_OFF   = 2'b00,
    CAP_RISE  = 2'b01,
    CAP_FALL  = 2'b10,
    CAP_PULSE = 2'b11
  } cap_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_HOLD
  } cap_state_e;

  localparam int unsigned CFG_PIN_LSB   = 0;
  localparam int unsigned CFG_PIN_W     = 5;
  localparam int unsigned CFG_MODE_LSB  = 5;
  localparam int unsigned CFG_MODE_W    = 2;
  localparam int unsigned CFG_REARM_BIT = 7;

  // Field order mirrors the configuration word, MSB first.
  typedef struct packed {
    logic                 rearm;
    cap_mode_e            mode;
    logic [CFG_PIN_W-1:0] pin;
  } cap_cfg_t;

  localparam cap_cfg_t CFG_RESET = '{rearm: 1'b0, mode: CAP_OFF, pin: '0};

  function automatic cap_cfg_t cfg_decode(input logic [7:0] word);
    cap_cfg_t c;
    c.pin   = word[CFG_PIN_LSB +: CFG_PIN_W];
    c.mode  = cap_mode_e'(word[CFG_MODE_LSB +: CFG_MODE_W]);
    c.rearm = word[CFG_REARM_BIT];
    return c;
  endfunction

  function automatic logic is_period_mode(input cap_mode_e m);
    return (m == CAP_RISE) || (m == CAP_FALL);
  endfunction

endpackage

// File: rtl/cog_cap_sync.sv
// Pin conditioning for the capture block: 2-flop synchronizer, optional
// 3-sample majority glitch filter, and a 1-flop edge delay producing
// single-cycle rise/fall strobes.
//
// Build option: define COG_CAP_FILTER_EN to insert the majority filter
// (rejects 1-cycle pulses, edge latency grows from 3 to 5 cycles).
//
// Ports:
//   clk_cog  in   cog clock
//   nres     in   asynchronous active-low reset
//   clr      in   synchronous clear of all history flops
//   pin      in   raw asynchronous pin
//   level    out  conditioned pin level
//   rise     out  one-cycle strobe on a 0->1 of level
//   fall     out  one-cycle strobe on a 1->0 of level
module cog_cap_sync (
  input  logic clk_cog,
  input  logic nres,
  input  logic clr,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;

`ifdef COG_CAP_FILTER_EN
  logic hist1_q;
  logic hist2_q;
  logic filt_q;
  logic maj;

  // Majority over three consecutive synchronized samples; registered so
  // that both edges see the same added latency.
  assign maj = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
      dly_q   <= 1'b0;
    end else if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= maj;
      dly_q   <= filt_q;
    end
  end

  assign level = filt_q;
`else
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign level = sync2_q;
`endif

  assign rise = level & ~dly_q;
  assign fall = ~level & dly_q;

endmodule

// File: rtl/cog_cap.sv
// Cog pin capture unit: measures period (rise-to-rise or fall-to-fall) or
// single high-pulse width of one selected pin, in clk_cog cycles, with
// high-time accumulation in period modes, overflow/lost-result flagging
// and optional back-to-back re-arming.
//
// Build option: COG_CAP_FILTER_EN enables the glitch filter inside
// cog_cap_sync (edge latency 5 cycles instead of 3).
//
// Ports:
//   clk_cog     in   cog clock
//   nres        in   asynchronous active-low reset
//   ena         in   cog enable; low forces IDLE and clears configuration
//   setcap      in   configuration write strobe
//   data        in   configuration word: [4:0] pin, [6:5] mode, [7] rearm
//   pin_in      in   raw pin inputs
//   rdcap       in   result acknowledge strobe
//   cap_period  out  last measured period / pulse width
//   cap_high    out  high time within the last period (0 in pulse mode)
//   cap_valid   out  unread result held
//   cap_ovf     out  counter saturated or an unread result was overwritten
module cog_cap
  import cog_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_cog,
  input  logic             nres,
  input  logic             ena,
  input  logic             setcap,
  input  logic [31:0]      data,
  input  logic [31:0]      pin_in,
  input  logic             rdcap,
  output logic [CNT_W-1:0] cap_period,
  output logic [CNT_W-1:0] cap_high,
  output logic             cap_valid,
  output logic             cap_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cap_cfg_t         cfg_q,  cfg_d;
  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, ovf_d;

  logic             lvl, rise, fall;
  logic             sync_clr;
  logic             per_mode;
  logic             start_evt, stop_evt;
  logic             end_evt, sat_evt;
  logic [CNT_W-1:0] hcnt_init;
  logic             data_unused;

  assign data_unused = ^data[31:8];

  // Reconfiguration discards pin history so a stale level on the old pin
  // cannot produce an edge on the new one.
  assign sync_clr = ena & setcap;

  cog_cap_sync u_sync (
    .clk_cog (clk_cog),
    .nres    (nres),
    .clr     (sync_clr),
    .pin     (pin_in[cfg_q.pin]),
    .level   (lvl),
    .rise    (rise),
    .fall    (fall)
  );

  assign per_mode  = is_period_mode(cfg_q.mode);
  assign start_evt = (cfg_q.mode == CAP_FALL) ? fall : rise;
  assign stop_evt  = (cfg_q.mode == CAP_RISE) ? rise : fall;
  // The start edge cycle itself counts toward high time when the pin is high.
  assign hcnt_init = (per_mode && lvl) ? CNT_ONE : '0;

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = cap_period;
    high_d   = cap_high;
    valid_d  = cap_valid;
    ovf_d    = cap_ovf;
    end_evt  = 1'b0;
    sat_evt  = 1'b0;

    if (!ena) begin
      state_d = ST_IDLE;
      cfg_d   = CFG_RESET;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else if (setcap) begin
      cfg_d   = cfg_decode(data[7:0]);
      state_d = (cfg_d.mode != CAP_OFF) ? ST_ARM : ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARM: begin
          if (start_evt) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
            hcnt_d  = hcnt_init;
          end
        end
        ST_MEASURE: begin
          if (stop_evt) begin
            end_evt  = 1'b1;
            period_d = cnt_q;
            high_d   = per_mode ? hcnt_q : '0;
            if (cfg_q.rearm && per_mode) begin
              cnt_d  = CNT_ONE;
              hcnt_d = hcnt_init;
            end else if (cfg_q.rearm) begin
              // A pulse ends on a fall, so restarting the count there would
              // time the low phase; wait for the next rise instead.
              state_d = ST_ARM;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            if (cnt_q == CNT_MAX) begin
              sat_evt = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
            if (per_mode && lvl && (hcnt_q != CNT_MAX)) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          if (rdcap) state_d = ST_ARM;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A fresh result beats an acknowledge in the same cycle; overwriting an
    // unread result is flagged unless that acknowledge arrived with it.
    if (end_evt) begin
      valid_d = 1'b1;
      ovf_d   = rdcap ? 1'b0 : (cap_valid | cap_ovf);
    end else begin
      if (rdcap) begin
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end
      if (sat_evt) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q    <= ST_IDLE;
      cfg_q      <= CFG_RESET;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      cap_period <= '0;
      cap_high   <= '0;
      cap_valid  <= 1'b0;
      cap_ovf    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      cap_period <= period_d;
      cap_high   <= high_d;
      cap_valid  <= valid_d;
      cap_ovf    <= ovf_d;
    end
  end

endmodule

// File: doc/cog_cap.md
COG_CAP -- requirements
Module: cog_cap

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the measurement counter and of the result registers.
REQ-002 clk_cog  in  1  cog clock; all state is clocked on its rising edge.
REQ-003 nres  in  1  reset, asynchronous and active-low; one clock domain only.
REQ-004 ena  in  1  cog enable; low forces IDLE and clears the configuration.
REQ-005 setcap  in  1  write strobe for the configuration from data.
REQ-006 data  in  32  configuration word: [4:0] pin, [6:5] mode, [7] irq_rearm.
REQ-007 pin_in  in  32  raw, asynchronous pin inputs.
REQ-008 rdcap  in  1  read strobe; acknowledges the current result.
REQ-009 cap_period  out  CNT_W  last measured period or width, in clk_cog cycles.
REQ-010 cap_high  out  CNT_W  high time within the last period (period modes only).
REQ-011 cap_valid  out  1  a result is held and has not been read.
REQ-012 cap_ovf  out  1  counter saturated, or a result was lost before it was read.

Function
REQ-013 Modes SHALL be: 00 off; 01 rise-to-rise period; 10 fall-to-fall period; 11 single high-pulse width.
REQ-014 The selected pin_in[pin] SHALL pass through a 2-flop synchronizer, then a 1-flop edge delay.
- Edge event fires 3 clk_cog cycles after the pin transition.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE and HOLD.
REQ-016 IDLE->ARM on setcap with mode != 00; any state->IDLE on setcap with mode 00, or when ena is low.
REQ-017 ARM->MEASURE on the start edge; the counter loads 1 on that cycle.
- Start edge: rise for modes 01 and 11, fall for mode 10.
REQ-018 In MEASURE the counter SHALL increment by 1 per cycle and saturate at all-ones.
- Saturation sets cap_ovf.
REQ-019 Period modes: a high-time counter SHALL increment on each MEASURE cycle where the synchronized pin is high.
REQ-020 End event: the next start edge (modes 01/10) or the falling edge (mode 11).
- On the end event: cap_period <= counter; cap_high <= high counter; cap_valid <= 1.
REQ-021 After the end event: with irq_rearm=1 the FSM stays in MEASURE and the counter restarts at 1 on that same edge (back-to-back periods); with irq_rearm=0 it goes to HOLD.
REQ-022 rdcap SHALL clear cap_valid and cap_ovf on the next cycle; in HOLD, rdcap -> ARM.
REQ-023 If an end event coincides with rdcap, the new result SHALL win: cap_valid stays 1, cap_ovf is cleared.
REQ-024 If an end event occurs while cap_valid is 1 and rdcap is absent, the results SHALL be overwritten and cap_ovf set to 1.
REQ-025 setcap SHALL take priority over all events in the same cycle; it clears the counters and the synchronizer history.
REQ-026 A pin that is stable forever SHALL leave the FSM in ARM or MEASURE; the counter saturates without wrapping.

Reset
REQ-027 nres low SHALL asynchronously set: FSM=IDLE, configuration=0, counters=0, cap_period=0, cap_high=0, cap_valid=0, cap_ovf=0, synchronizer flops=0.
REQ-028 Reset deassertion mid-measurement SHALL NOT produce a result; the block restarts from IDLE.

Configuration
REQ-029 Macro COG_CAP_FILTER_EN defined: a 3-sample majority glitch filter SHALL sit after the synchronizer.
- Pulses of 1 cycle are rejected.
- Edge latency becomes 5 cycles.
REQ-030 Macro COG_CAP_FILTER_EN undefined: no filter; edge latency is 3 cycles; results are otherwise identical.

Structure
REQ-031 The package cog_pkg SHALL hold the mode encodings (CAP_OFF, CAP_RISE, CAP_FALL, CAP_PULSE), the FSM state typedef and the config bit-field positions.
REQ-032 One sub-module, cog_cap_sync, SHALL contain the synchronizer, the optional filter and the edge detector.
- It outputs level, rise and fall.

Verification
REQ-033 Mode 01, pin 5, pin toggling 40 cycles high / 60 cycles low, irq_rearm=1 -> cap_period=100 and cap_high=40 every period; cap_valid set each period.
REQ-034 Mode 11, a 17-cycle high pulse -> cap_period=17, cap_valid=1, FSM in HOLD; then rdcap -> cap_valid=0, FSM in ARM.
REQ-035 Mode 01 with CNT_W=8, pin held low after the start edge -> cap_period saturates at 255 and cap_ovf=1.
REQ-036 Mode 10, two periods complete with no rdcap -> second result visible and cap_ovf=1; end event coinciding with rdcap -> cap_valid=1, cap_ovf=0.
REQ-037 nres pulsed low mid-MEASURE -> all outputs 0 immediately, FSM in IDLE; ena low -> IDLE.
REQ-038 With COG_CAP_FILTER_EN defined, a 1-cycle glitch -> no edge event; a 3-cycle pulse -> measured with 5-cycle latency.
